ifu_step_ctrl: RTL



---
 rtl/ifu_step_ctrl_pkg.sv | 25 ++
 rtl/ifu_step_ctrl_btn_debounce.sv | 58 +++++
 rtl/ifu_step_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/ifu_step_ctrl_pkg.sv
// Shared constants and state encoding for the fetch / step-control stage.
// Imported by ifu_step_ctrl and its debouncer.
package ifu_step_ctrl_pkg;

  localparam int ADDR_W_DEF        = 6;
  localparam int TICK_BIT_FAST_DEF = 25;
  localparam int TICK_BIT_SLOW_DEF = 27;
  localparam int DB_CYCLES_DEF     = 1000000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_INCR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    LATCH = S_LATCH,
    INCR  = S_INCR
  } state_t;

  // Width of a counter that must reach n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifu_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter,
// and a single-cycle pulse on each accepted press.
module btn_debounce
  import ifu_step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn,
  output logic press
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          stable_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Any disagreement that clears before CNT_LAST is treated as bounce.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync2 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt    <= '0;
      stable <= sync2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stable_q <= 1'b0;
    end else begin
      stable_q <= stable;
    end
  end

  assign press = stable & ~stable_q;

endmodule

// File: rtl/ifu_step_ctrl.sv
// Fetch / step-control stage: owns the ROM address, latches the fetched
// word, and advances on a divided run tick or a debounced step press.
module ifu_step_ctrl
  import ifu_step_ctrl_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int TICK_BIT_FAST = TICK_BIT_FAST_DEF,
  parameter int TICK_BIT_SLOW = TICK_BIT_SLOW_DEF,
  parameter int DB_CYCLES     = DB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run_i,
  input  logic              speed_i,
  input  logic              hold_i,
  input  logic              step_btn_i,
  input  logic [ADDR_W-1:0] prog_len_i,
  input  logic [31:0]       im_data_i,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic              wrap_o,
  output logic [1:0]        state_o
);

  logic [TICK_BIT_SLOW:0] div;
  logic                   sel;
  logic                   sel_q;
  logic                   tick;
  logic                   step;
  logic                   adv;
  logic [ADDR_W-1:0]      last;
  state_t                 state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div   <= '0;
      sel_q <= 1'b0;
    end else begin
      div   <= div + 1'b1;
      sel_q <= sel;
    end
  end

  assign sel  = speed_i ? div[TICK_BIT_SLOW] : div[TICK_BIT_FAST];
  assign tick = sel & ~sel_q;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_db (
    .clk   (clk),
    .rstn  (rstn),
    .btn   (step_btn_i),
    .press (step)
  );

  always_comb begin
    adv = 1'b0;
    priority case (1'b1)
      hold_i:  adv = 1'b0;
      run_i:   adv = tick;
      default: adv = step;
    endcase
  end

  // prog_len_i == 0 wraps naturally to the all-ones address.
  assign last = prog_len_i - 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      im_addr_o     <= '0;
      instr_o       <= '0;
      instr_valid_o <= 1'b0;
      wrap_o        <= 1'b0;
    end else begin
      instr_valid_o <= 1'b0;
      wrap_o        <= 1'b0;
      case (state)
        LATCH: begin
          instr_o       <= im_data_i;
          instr_valid_o <= 1'b1;
          state         <= INCR;
        end
        INCR: begin
          if (im_addr_o >= last) begin
            im_addr_o <= '0;
            wrap_o    <= 1'b1;
          end else begin
            im_addr_o <= im_addr_o + 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state <= adv ? LATCH : IDLE;
        end
      endcase
    end
  end

  assign pc_o    = 32'({im_addr_o, 2'b00});
  assign state_o = state;

endmodule
